// File: rtl/stack_eval_unit.sv
// Expression evaluator between an operand stack and an operator stack.
// Pops one operator and two operands, pushes the result, and repeats until the operator stack is empty.
module stack_eval_unit #(
   parameter int DW   = 8,
   parameter int SAT  = 0,
   parameter int CNTW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [DW-1:0]   opndSTK_Dout,
   input  logic            opndSTK_empty,
   input  logic [1:0]      opSTK_Dout,
   input  logic            opSTK_empty,
   output logic            opndSTK_pop,
   output logic            opndSTK_push,
   output logic [DW-1:0]   opndSTK_Din,
   output logic            opSTK_pop,
   output logic [1:0]      op,
   output logic [DW-1:0]   R,
   output logic            busy,
   output logic            complete,
   output logic            error,
   output logic [1:0]      err_code,
   output logic            ovf,
   output logic [CNTW-1:0] ops_cnt
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_POP_B  = 4'd2,
      S_POP_A  = 4'd3,
      S_EXEC   = 4'd4,
      S_PUSH   = 4'd5,
      S_FINAL  = 4'd6,
      S_CHKEND = 4'd7,
      S_DONE   = 4'd8,
      S_ERR    = 4'd9
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [1:0]      w_code;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [DW-1:0]   r_res;
   logic [DW-1:0]   r_fin;
   logic [DW-1:0]   r_R;
   logic [1:0]      r_op;
   logic            r_error;
   logic [1:0]      r_err_code;
   logic            r_ovf;
   logic [CNTW-1:0] r_ops_cnt;
   logic [DW:0]     w_sum;
   logic [DW:0]     w_diff;
   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_quot;
   logic [DW-1:0]   w_res;
   logic            w_ovf;

   // Arithmetic on the latched operands; a is the deeper operand, b the top.
   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, r_b};
      w_diff = {1'b0, r_a} - {1'b0, r_b};
      w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, r_b};
      if (r_b == {DW{1'b0}}) begin
         w_quot = {DW{1'b0}};
      end else begin
         w_quot = r_a / r_b;
      end
      w_res = {DW{1'b0}};
      w_ovf = 1'b0;
      case (r_op)
         2'b00: begin
            w_ovf = w_sum[DW];
            if (w_sum[DW] && (SAT != 32'sd0)) w_res = {DW{1'b1}};
            else                              w_res = w_sum[DW-1:0];
         end
         2'b01: begin
            // a borrow out of the extended subtract means a < b
            w_ovf = w_diff[DW];
            if (w_diff[DW] && (SAT != 32'sd0)) w_res = {DW{1'b0}};
            else                               w_res = w_diff[DW-1:0];
         end
         2'b10: begin
            w_ovf = |w_prod[2*DW-1:DW];
            if (w_ovf && (SAT != 32'sd0)) w_res = {DW{1'b1}};
            else                          w_res = w_prod[DW-1:0];
         end
         2'b11: begin
            w_ovf = 1'b0;
            w_res = w_quot;
         end
         default: begin
            w_ovf = 1'b0;
            w_res = {DW{1'b0}};
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic and the error code that accompanies an ERR transition.
   always_comb begin
      w_next = r_state;
      w_code = 2'b00;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH; else w_next = S_IDLE;
         S_FETCH:  if (opSTK_empty) w_next = S_FINAL; else w_next = S_POP_B;
         S_POP_B: begin
            if (opndSTK_empty) begin w_next = S_ERR; w_code = 2'b01; end
            else               w_next = S_POP_A;
         end
         S_POP_A: begin
            if (opndSTK_empty) begin w_next = S_ERR; w_code = 2'b01; end
            else               w_next = S_EXEC;
         end
         S_EXEC: begin
            if ((r_op == 2'b11) && (r_b == {DW{1'b0}})) begin w_next = S_ERR; w_code = 2'b10; end
            else                                         w_next = S_PUSH;
         end
         S_PUSH:   w_next = S_FETCH;
         S_FINAL: begin
            if (opndSTK_empty) begin w_next = S_ERR; w_code = 2'b01; end
            else               w_next = S_CHKEND;
         end
         S_CHKEND: begin
            if (!opndSTK_empty) begin w_next = S_ERR; w_code = 2'b11; end
            else                w_next = S_DONE;
         end
         S_DONE:   w_next = S_IDLE;
         S_ERR:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Datapath and status registers; R is committed only once the stack is known to be clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a        <= {DW{1'b0}};
         r_b        <= {DW{1'b0}};
         r_res      <= {DW{1'b0}};
         r_fin      <= {DW{1'b0}};
         r_R        <= {DW{1'b0}};
         r_op       <= 2'b00;
         r_error    <= 1'b0;
         r_err_code <= 2'b00;
         r_ovf      <= 1'b0;
         r_ops_cnt  <= {CNTW{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_error    <= 1'b0;
                  r_err_code <= 2'b00;
                  r_ovf      <= 1'b0;
                  r_ops_cnt  <= {CNTW{1'b0}};
               end
            end
            S_FETCH:  if (!opSTK_empty)   r_op  <= opSTK_Dout;
            S_POP_B:  if (!opndSTK_empty) r_b   <= opndSTK_Dout;
            S_POP_A:  if (!opndSTK_empty) r_a   <= opndSTK_Dout;
            S_EXEC: begin
               if (w_next == S_PUSH) begin
                  r_res <= w_res;
                  r_ovf <= r_ovf | w_ovf;
               end
            end
            S_PUSH:   r_ops_cnt <= r_ops_cnt + CNTW'(1);
            S_FINAL:  if (!opndSTK_empty) r_fin <= opndSTK_Dout;
            S_CHKEND: if (opndSTK_empty)  r_R   <= r_fin;
            default:  r_ops_cnt <= r_ops_cnt;
         endcase
         if (w_next == S_ERR) begin
            r_error    <= 1'b1;
            r_err_code <= w_code;
         end
      end
   end

   // Stack strobes and handshake outputs decoded from the current state.
   always_comb begin
      opSTK_pop    = 1'b0;
      opndSTK_pop  = 1'b0;
      opndSTK_push = 1'b0;
      busy         = 1'b0;
      complete     = 1'b0;
      case (r_state)
         S_FETCH: begin
            busy      = 1'b1;
            opSTK_pop = !opSTK_empty;
         end
         S_POP_B, S_POP_A, S_FINAL: begin
            busy        = 1'b1;
            opndSTK_pop = !opndSTK_empty;
         end
         S_EXEC, S_CHKEND: busy = 1'b1;
         S_PUSH: begin
            busy         = 1'b1;
            opndSTK_push = 1'b1;
         end
         S_DONE, S_ERR: complete = 1'b1;
         default:       busy     = 1'b0;
      endcase
   end

   assign opndSTK_Din = r_res;
   assign op          = r_op;
   assign R           = r_R;
   assign error       = r_error;
   assign err_code    = r_err_code;
   assign ovf         = r_ovf;
   assign ops_cnt     = r_ops_cnt;

endmodule
